// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial_deser deserializer.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_outbuf.sv
// One-word valid/ready output buffer for serial_deser: holds data and parity
// sideband, tracks sticky overrun and counts words written into the buffer.
module deser_outbuf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_perr,
  input  logic             data_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             parity_err,
  output logic             overrun,
  output logic [CNT_W-1:0] word_count
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    accept  = push && (!valid_q || data_ready);

    if (valid_q && data_ready) valid_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = push_data;
      perr_d  = push_perr;
      cnt_d   = cnt_q + 1'b1;
    end

    // Set has priority over a simultaneous clear.
    if (ovr_clr) ovr_d = 1'b0;
    if (push && !accept) ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign word_count = cnt_q;

endmodule

// File: rtl/serial_deser.sv
// Framed serial-to-parallel deserializer with one-word output buffer.
// Optional trailing even-parity bit enabled by defining SERIAL_DESER_PARITY_EN.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned CONTINUOUS = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sda,
  input  logic             frame,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned     CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             ferr_q, ferr_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wperr_q, wperr_d;
  logic             perr_d;
`ifdef SERIAL_DESER_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic bit_in);
    if (MSB_FIRST != 0) return {cur[WIDTH-2:0], bit_in};
    else                return {bit_in, cur[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ferr_d  = 1'b0;
    done_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    par_d   = par_q;
`endif

    if (en) begin
      if (frame) begin
        // A frame at a word boundary (IDLE, or SHIFT with count 0) is a clean start.
        ferr_d  = (state_q == PAR) || ((state_q == SHIFT) && (cnt_q != '0));
        state_d = SHIFT;
        cnt_d   = CW'(1);
        sr_d    = shift_in('0, sda);
`ifdef SERIAL_DESER_PARITY_EN
        par_d   = sda;
`endif
      end else begin
        unique case (state_q)
          SHIFT: begin
            sr_d  = shift_in(sr_q, sda);
            cnt_d = cnt_q + 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
            par_d = par_q ^ sda;
            if (cnt_d == LAST_CNT) state_d = PAR;
`else
            if (cnt_d == LAST_CNT) begin
              done_d = 1'b1;
              cnt_d  = '0;
              if (CONTINUOUS != 0) state_d = SHIFT;
              else                 state_d = IDLE;
            end
`endif
          end
          PAR: begin
            cnt_d = '0;
`ifdef SERIAL_DESER_PARITY_EN
            done_d = 1'b1;
            perr_d = par_q ^ sda;
            if (CONTINUOUS != 0) state_d = SHIFT;
            else                 state_d = IDLE;
`else
            state_d = IDLE;
`endif
          end
          default: ;
        endcase
      end
    end

    // Completed word is staged one cycle ahead of the output buffer.
    word_d  = done_d ? sr_d : word_q;
    wperr_d = done_d ? perr_d : wperr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
      wperr_q <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
      word_q  <= word_d;
      wperr_q <= wperr_d;
`ifdef SERIAL_DESER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign busy      = ((state_q == SHIFT) && (cnt_q != '0)) || (state_q == PAR);
  assign frame_err = ferr_q;

  deser_outbuf #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_outbuf (
    .clk        (clk),
    .reset      (reset),
    .push       (done_q),
    .push_data  (word_q),
    .push_perr  (wperr_q),
    .data_ready (data_ready),
    .ovr_clr    (ovr_clr),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .overrun    (overrun),
    .word_count (word_count)
  );

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser: MSB-first and LSB-first instances share
// stimulus; delivered words are checked against a scoreboard queue.
module tb_serial_deser;

`ifdef SERIAL_DESER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, en, sda, frame, data_ready, ovr_clr;
  logic [7:0]  data, data_l;
  logic        data_valid, data_valid_l, parity_err, parity_err_l;
  logic        frame_err, frame_err_l, overrun, overrun_l, busy, busy_l;
  logic [15:0] word_count, word_count_l;

  always #5 clk = ~clk;

  serial_deser #(.WIDTH(8), .MSB_FIRST(1), .CONTINUOUS(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .sda(sda), .frame(frame),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .ovr_clr(ovr_clr), .busy(busy), .word_count(word_count)
  );

  serial_deser #(.WIDTH(8), .MSB_FIRST(0), .CONTINUOUS(0), .CNT_W(16)) dut_l (
    .clk(clk), .reset(reset), .en(en), .sda(sda), .frame(frame),
    .data(data_l), .data_valid(data_valid_l), .data_ready(data_ready),
    .parity_err(parity_err_l), .frame_err(frame_err_l), .overrun(overrun_l),
    .ovr_clr(ovr_clr), .busy(busy_l), .word_count(word_count_l)
  );

  typedef struct {
    logic [7:0] bits;     // bits[7] is transmitted first
    bit         par_bad;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [7:0] dl;
    logic       pe;
  } exp_t;

  vec_t  vecs[5];
  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_wc  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic [7:0] dl, input logic pe);
    exp_t e;
    e.d = d; e.dl = dl; e.pe = pe;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic e, input logic f, input logic s);
    en = e; frame = f; sda = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) drive_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [7:0] bits, input bit par_bad,
                           input logic exp_ferr, input int unsigned gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 4 && gap != 0) begin
        idle(gap);
        chk("busy_gap", busy, 1'b1);
      end
      drive_bit(1'b1, i == 0, bits[7-i]);
      if (i == 0) begin
        chk("frame_err_first", frame_err, exp_ferr);
        chk("busy_first", busy, 1'b1);
      end
      if (i == 1) chk("frame_err_pulse_end", frame_err, 1'b0);
    end
    if (PAR_ON) drive_bit(1'b1, 1'b0, (^bits) ^ par_bad);
    en = 1'b0; frame = 1'b0; sda = 1'b0;
  endtask

  // Scoreboard: pop on every handshake seen by the MSB-first instance.
  always @(negedge clk) begin
    if (!reset && data_valid && data_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", data, 8'h00);
        n_fail++;
        $display("FAIL sb_empty_pop: got word %0h, none expected", data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data_msb", data, e.d);
        chk("sb_valid_lsb", data_valid_l, 1'b1);
        chk("sb_data_lsb", data_l, e.dl);
        chk("sb_parity", parity_err, e.pe);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{bits: 8'hA5, par_bad: 1'b0, exp_msb: 8'hA5, exp_lsb: 8'hA5};
    vecs[1] = '{bits: 8'h80, par_bad: 1'b0, exp_msb: 8'h80, exp_lsb: 8'h01};
    vecs[2] = '{bits: 8'h3C, par_bad: 1'b1, exp_msb: 8'h3C, exp_lsb: 8'h3C};
    vecs[3] = '{bits: 8'hC1, par_bad: 1'b0, exp_msb: 8'hC1, exp_lsb: 8'h83};
    vecs[4] = '{bits: 8'h12, par_bad: 1'b0, exp_msb: 8'h12, exp_lsb: 8'h48};

    reset = 1'b1; en = 1'b0; sda = 1'b0; frame = 1'b0;
    data_ready = 1'b1; ovr_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_data", data, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_parity", parity_err, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_word_count", word_count, 16'd0);
    idle(2);

    // First word with explicit latency check.
    push_exp(8'hA5, 8'hA5, 1'b0);
    send_word(8'hA5, 1'b0, 1'b0, 0);
    chk("lat_not_yet", data_valid, 1'b0);
    idle(1);
    chk("lat_valid", data_valid, 1'b1);
    chk("lat_data", data, 8'hA5);
    exp_wc++;
    chk("lat_word_count", word_count, 16'(exp_wc));
    idle(3);
    chk("lat_valid_fall", data_valid, 1'b0);

    for (int i = 0; i < 5; i++) begin
      push_exp(vecs[i].exp_msb, vecs[i].exp_lsb, PAR_ON & vecs[i].par_bad);
      send_word(vecs[i].bits, vecs[i].par_bad, 1'b0, 0);
      idle(3);
      exp_wc++;
      chk("tbl_word_count", word_count, 16'(exp_wc));
    end

    // en held low for 3 cycles mid-word.
    push_exp(8'hA5, 8'hA5, 1'b0);
    send_word(8'hA5, 1'b0, 1'b0, 3);
    chk("gap_not_yet", data_valid, 1'b0);
    idle(1);
    chk("gap_valid", data_valid, 1'b1);
    chk("gap_data", data, 8'hA5);
    idle(2);
    exp_wc++;

    // Overrun with consumer stalled.
    data_ready = 1'b0;
    push_exp(8'h11, rev8(8'h11), 1'b0);
    send_word(8'h11, 1'b0, 1'b0, 0);
    send_word(8'h22, 1'b0, 1'b0, 0);
    idle(3);
    exp_wc++;
    chk("ovr_data", data, 8'h11);
    chk("ovr_data_lsb", data_l, rev8(8'h11));
    chk("ovr_valid", data_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_flag_lsb", overrun_l, 1'b1);
    chk("ovr_word_count", word_count, 16'(exp_wc));
    idle(2);
    chk("ovr_sticky", overrun, 1'b1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 1'b0);
    data_ready = 1'b1;
    idle(3);
    chk("ovr_drained", data_valid, 1'b0);

    // Frame reasserted after 4 bits: partial word discarded.
    drive_bit(1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b1);
    chk("resync_busy", busy, 1'b1);
    chk("resync_no_ferr_yet", frame_err, 1'b0);
    push_exp(8'h5A, rev8(8'h5A), 1'b0);
    send_word(8'h5A, 1'b0, 1'b1, 0);
    idle(3);
    exp_wc++;
    chk("resync_word_count", word_count, 16'(exp_wc));

    // Reset mid-word.
    drive_bit(1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b1);
    en = 1'b0; frame = 1'b0;
    reset = 1'b1;
    #2;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_word_count", word_count, 16'd0);
    reset = 1'b0;
    exp_wc = 0;
    idle(2);
    chk("midrst_no_word", data_valid, 1'b0);
    push_exp(8'hC3, rev8(8'hC3), 1'b0);
    send_word(8'hC3, 1'b0, 1'b0, 0);
    idle(3);
    exp_wc++;
    chk("midrst_word_count2", word_count, 16'(exp_wc));

`ifdef SERIAL_DESER_PARITY_EN
    push_exp(8'hA5, 8'hA5, 1'b1);
    send_word(8'hA5, 1'b1, 1'b0, 0);
    idle(1);
    chk("par_bad_flag", parity_err, 1'b1);
    idle(2);
    push_exp(8'hA5, 8'hA5, 1'b0);
    send_word(8'hA5, 1'b0, 1'b0, 0);
    idle(1);
    chk("par_good_flag", parity_err, 1'b0);
    idle(2);
`endif

    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
